// File: rtl/cga_intr_cntlr_irq_vec.sv
// Vectored interrupt controller: synchronises active-low requests, latches them into a
// pending register and presents the highest enabled pending level with an ACK handshake.
module cga_intr_cntlr_irq_vec #(
    parameter  int LEVELS      = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int LW          = $clog2(LEVELS)
) (
    input  logic              CP,
    input  logic              CLRN,
    input  logic [LEVELS-1:0] RQN,
    input  logic [LEVELS-1:0] EDGE,
    input  logic [LEVELS-1:0] PIE,
    input  logic [LEVELS-1:0] CLRBIT,
    input  logic              ACK,
    output logic [LEVELS-1:0] INR,
    output logic              IRQ,
    output logic [LW-1:0]     LVL
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    logic [SYNC_STAGES-1:0][LEVELS-1:0] r_sync;
    logic [LEVELS-1:0]                  r_req_d;
    logic [LEVELS-1:0]                  r_inr;
    logic                               r_irq;
    logic [LW-1:0]                      r_lvl;
    state_t                             r_state;

    logic [LEVELS-1:0] w_req_s;
    logic [LEVELS-1:0] w_set;
    logic [LEVELS-1:0] w_clr;
    logic [LEVELS-1:0] w_pend;
    logic              w_ack_acc;
    logic              w_irq;
    logic [LW-1:0]     w_lvl;

    assign w_req_s   = r_sync[SYNC_STAGES-1];
    assign w_set     = (EDGE & w_req_s & ~r_req_d) | (~EDGE & w_req_s);
    assign w_ack_acc = ACK && r_irq && (r_state == ST_IDLE);
    assign w_clr     = CLRBIT | (w_ack_acc ? (LEVELS'(1) << r_lvl) : '0);
    assign w_pend    = r_inr & PIE;

    // Ascending scan: the last hit is the highest index, which has top priority.
    always_comb begin
        w_lvl = '0;
        w_irq = |w_pend;
        for (int i = 0; i < LEVELS; i++)
            if (w_pend[i]) w_lvl = LW'(i);
    end

    always_ff @(posedge CP or negedge CLRN) begin
        if (!CLRN) begin
            r_sync  <= '0;
            r_req_d <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ~RQN};
            r_req_d <= w_req_s;
        end
    end

    // Set is OR'd in after the clear so a coincident new event is never lost.
    always_ff @(posedge CP or negedge CLRN) begin
        if (!CLRN) begin
            r_inr <= '0;
            r_irq <= 1'b0;
            r_lvl <= '0;
        end else begin
            r_inr <= (r_inr & ~w_clr) | w_set;
            r_irq <= w_irq;
            r_lvl <= w_lvl;
        end
    end

    // BUSY lasts exactly one edge so the stale LVL registered alongside the ACK is skipped.
    always_ff @(posedge CP or negedge CLRN) begin
        if (!CLRN) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_ack_acc) r_state <= ST_BUSY;
                ST_BUSY: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign INR = r_inr;
    assign IRQ = r_irq;
    assign LVL = r_lvl;

endmodule

// File: tb/tb_cga_intr_cntlr_irq_vec.sv
// Bench for cga_intr_cntlr_irq_vec: directed scenarios plus randomized traffic, all
// checked against a cycle-indexed behavioural model of the pending/priority rules.
module tb_cga_intr_cntlr_irq_vec;
    localparam int LEVELS = 16;
    localparam int S      = 2;
    localparam int LW     = $clog2(LEVELS);

    logic              CP = 1'b0;
    logic              CLRN;
    logic [LEVELS-1:0] RQN, EDGE, PIE, CLRBIT;
    logic              ACK;
    logic [LEVELS-1:0] INR;
    logic              IRQ;
    logic [LW-1:0]     LVL;

    int n_chk = 0;
    int n_fail = 0;

    cga_intr_cntlr_irq_vec #(.LEVELS(LEVELS), .SYNC_STAGES(S)) dut (
        .CP(CP), .CLRN(CLRN), .RQN(RQN), .EDGE(EDGE), .PIE(PIE),
        .CLRBIT(CLRBIT), .ACK(ACK), .INR(INR), .IRQ(IRQ), .LVL(LVL)
    );

    always #5 CP = ~CP;

    // Model: hist[k] is the active-high request vector sampled k edges ago (0 = this edge).
    bit [LEVELS-1:0] hist[$];
    bit [LEVELS-1:0] m_inr;
    bit              m_irq;
    int              m_lvl;
    bit              m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_inr  = '0;
        m_irq  = 1'b0;
        m_lvl  = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_step();
        bit [LEVELS-1:0] rs, rd, set, clr, pend;
        bit acc;
        int top;
        hist.push_front(~RQN);
        if (hist.size() > S + 2) void'(hist.pop_back());
        rs  = (hist.size() > S)     ? hist[S]     : '0;
        rd  = (hist.size() > S + 1) ? hist[S + 1] : '0;
        set = '0;
        for (int i = 0; i < LEVELS; i++)
            set[i] = EDGE[i] ? (rs[i] && !rd[i]) : rs[i];
        acc = ACK && m_irq && !m_busy;
        clr = CLRBIT;
        if (acc) clr[m_lvl] = 1'b1;
        pend = m_inr & PIE;
        top = 0;
        for (int i = LEVELS - 1; i >= 0; i--)
            if (pend[i]) begin top = i; break; end
        m_irq  = (pend != 0);
        m_lvl  = top;
        m_inr  = (m_inr & ~clr) | set;
        m_busy = acc;
    endtask

    task automatic tick();
        @(posedge CP);
        model_step();
        #1;
        chk("INR", INR, m_inr);
        chk("IRQ", IRQ, m_irq);
        chk("LVL", LVL, m_lvl);
        @(negedge CP);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset pulse placed between two rising edges.
    task automatic async_rst();
        #2 CLRN = 1'b0;
        #1;
        chk("RST_INR", INR, 0);
        chk("RST_IRQ", IRQ, 0);
        chk("RST_LVL", LVL, 0);
        model_reset();
        #1 CLRN = 1'b1;
    endtask

    initial begin
        CLRN = 1'b0; RQN = '1; EDGE = '1; PIE = '1; CLRBIT = '0; ACK = 1'b0;
        model_reset();
        #3;
        chk("RST0_INR", INR, 0);
        chk("RST0_IRQ", IRQ, 0);
        chk("RST0_LVL", LVL, 0);
        @(negedge CP);
        CLRN = 1'b1;

        // Edge-mode latency on level 5.
        RQN[5] = 1'b0;
        ticks(2);
        chk("LAT_INR5_E2", INR[5], 0);
        tick();
        chk("LAT_INR5_E3", INR[5], 1);
        chk("LAT_IRQ_E3", IRQ, 0);
        tick();
        chk("LAT_IRQ_E4", IRQ, 1);
        chk("LAT_LVL_E4", LVL, 5);
        CLRBIT[5] = 1'b1; RQN[5] = 1'b1;
        tick();
        CLRBIT = '0;
        ticks(3);

        // Two simultaneous requests served in priority order; ACK held through BUSY.
        RQN[3] = 1'b0; RQN[12] = 1'b0;
        ticks(4);
        chk("PRI_LVL12", LVL, 12);
        ACK = 1'b1;
        tick();
        chk("PRI_INR12_CLR", INR[12], 0);
        tick();
        chk("PRI_BUSY_INR3", INR[3], 1);
        chk("PRI_LVL3", LVL, 3);
        tick();
        chk("PRI_INR_EMPTY", INR, 0);
        ACK = 1'b0;
        tick();
        chk("PRI_IRQ_OFF", IRQ, 0);
        RQN = '1;
        ticks(3);

        // Level mode: an acknowledged level still requested re-pends.
        EDGE[7] = 1'b0; RQN[7] = 1'b0;
        ticks(4);
        chk("LVM_LVL7", LVL, 7);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("LVM_INR7", INR[7], 1);
        tick();
        chk("LVM_IRQ", IRQ, 1);
        RQN[7] = 1'b1;
        ticks(3);
        CLRBIT[7] = 1'b1;
        tick();
        CLRBIT = '0; EDGE = '1;
        ticks(2);

        // Masked level latches but does not raise IRQ until enabled.
        PIE[9] = 1'b0; RQN[9] = 1'b0;
        tick();
        RQN[9] = 1'b1;
        ticks(4);
        chk("MSK_INR9", INR[9], 1);
        chk("MSK_IRQ0", IRQ, 0);
        PIE[9] = 1'b1;
        tick();
        chk("MSK_IRQ1", IRQ, 1);
        chk("MSK_LVL9", LVL, 9);
        CLRBIT[9] = 1'b1;
        tick();
        CLRBIT = '0;
        ticks(2);

        // Clear coincident with a set loses to the set; clear alone wins.
        RQN[4] = 1'b0;
        ticks(2);
        CLRBIT[4] = 1'b1;
        tick();
        chk("CLR_SETWIN", INR[4], 1);
        tick();
        chk("CLR_ALONE", INR[4], 0);
        CLRBIT = '0; RQN[4] = 1'b1;
        ticks(3);

        // Reset while BUSY with levels 15 and 0 pending (level mode keeps them set).
        EDGE = '0; RQN[15] = 1'b0; RQN[0] = 1'b0;
        ticks(4);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("RBSY_INR", INR, 16'h8001);
        async_rst();
        EDGE = '1; RQN = '1;
        ticks(4);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < LEVELS; i++)
                if ($urandom_range(0, 15) == 0) RQN[i] = ~RQN[i];
            if (c % 250 == 0) EDGE = LEVELS'($urandom);
            if ($urandom_range(0, 19) == 0) PIE = LEVELS'($urandom | $urandom);
            CLRBIT = LEVELS'($urandom & $urandom & $urandom);
            ACK = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) async_rst();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
